// File: rtl/exu_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : exu_seq_ctrl_pkg
// Brief   : Sequencer state encoding, decoded-instruction indices and class decode
// Rev     : 1.0  initial release
// ============================================================================
package exu_seq_ctrl_pkg;

  localparam int ISA_WIDTH_DEF      = 32;
  localparam int INST_NUM_WIDTH_DEF = 5;
  localparam int TIMEOUT_CYC_DEF    = 255;
  localparam int CNT_WIDTH_DEF      = 64;
  localparam int WDOG_W             = 8;

  localparam logic [3:0] S_RST  = 4'd0;
  localparam logic [3:0] S_IF   = 4'd1;
  localparam logic [3:0] S_IFW  = 4'd2;
  localparam logic [3:0] S_EX   = 4'd3;
  localparam logic [3:0] S_MEM  = 4'd4;
  localparam logic [3:0] S_MEMW = 4'd5;
  localparam logic [3:0] S_WB   = 4'd6;
  localparam logic [3:0] S_HALT = 4'd7;
  localparam logic [3:0] S_ERR  = 4'd8;

  // Indices at or above INST_COUNT are undecoded and behave as ebreak.
  typedef enum logic [INST_NUM_WIDTH_DEF-1:0] {
    INST_LUI, INST_AUIPC, INST_JAL, INST_JALR, INST_BEQ, INST_BNE,
    INST_LW, INST_LBU, INST_SH, INST_SW, INST_ADDI, INST_SLTIU, INST_SRAI,
    INST_ADD, INST_SUB, INST_XOR, INST_OR, INST_AND, INST_SLTU, INST_SLL,
    INST_SRL, INST_SRA, INST_EBREAK, INST_COUNT
  } inst_e;

  typedef struct packed {
    logic is_mem;
    logic is_store;
    logic no_rd;
    logic is_halt;
  } inst_class_t;

  function automatic inst_class_t decode_class(input logic [INST_NUM_WIDTH_DEF-1:0] idx);
    inst_class_t c;
    c = '0;
    case (idx)
      INST_LW, INST_LBU: c.is_mem = 1'b1;
      INST_SH, INST_SW: begin
        c.is_mem   = 1'b1;
        c.is_store = 1'b1;
        c.no_rd    = 1'b1;
      end
      INST_BEQ, INST_BNE: c.no_rd = 1'b1;
      INST_EBREAK: begin
        c.is_halt = 1'b1;
        c.no_rd   = 1'b1;
      end
      default: begin
        if (idx >= INST_COUNT) begin
          c.is_halt = 1'b1;
          c.no_rd   = 1'b1;
        end
      end
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/exu_seq_wdog.sv
`default_nettype none
// ============================================================================
// Module  : exu_seq_wdog
// Brief   : Memory-phase watchdog: 8-bit clear/enable counter with expiry flag
// Rev     : 1.0  initial release
// ============================================================================
module exu_seq_wdog
  import exu_seq_ctrl_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WDOG_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= r_cnt + WDOG_W'(1);
    end
  end

  // Flags the LIMIT-th enabled cycle so the owner leaves on that edge.
  assign expired = en & (r_cnt == WDOG_W'(LIMIT - 1));

endmodule
`default_nettype wire

// File: rtl/exu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : exu_seq_ctrl
// Brief   : Multi-cycle fetch/execute/memory/writeback sequencer with bus watchdog
// Rev     : 1.0  initial release
// ============================================================================
module exu_seq_ctrl
  import exu_seq_ctrl_pkg::*;
#(
  parameter int ISA_WIDTH      = ISA_WIDTH_DEF,
  parameter int INST_NUM_WIDTH = INST_NUM_WIDTH_DEF,
  parameter int TIMEOUT_CYC    = TIMEOUT_CYC_DEF,
  parameter int CNT_WIDTH      = CNT_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [INST_NUM_WIDTH-1:0] inst_num,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_fetch,
  output logic                      mem_req_wen,
  input  logic                      mem_rsp_valid,
  output logic                      ir_wen,
  output logic                      mem_r_wen,
  output logic                      pc_wen,
  output logic                      rf_wen,
  output logic                      halt,
  output logic                      bus_err,
  output logic [CNT_WIDTH-1:0]      cycle_cnt,
  output logic [CNT_WIDTH-1:0]      inst_cnt
);

  localparam int IDX_W = INST_NUM_WIDTH_DEF;

  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > (1 << WDOG_W) - 1) begin : g_chk_timeout
    $error("exu_seq_ctrl: TIMEOUT_CYC out of watchdog range");
  end
  if (ISA_WIDTH != 32 && ISA_WIDTH != 64) begin : g_chk_isa
    $error("exu_seq_ctrl: unsupported ISA_WIDTH");
  end

  logic [3:0]       r_state;
  logic [3:0]       w_next_state;
  logic [IDX_W-1:0] w_idx;
  logic             w_idx_oor;
  inst_class_t      w_cls_dec;
  inst_class_t      w_cls;
  logic             w_st_if, w_st_ifw, w_st_mem, w_st_memw, w_st_wb, w_st_ex;
  logic             w_req, w_in_phase, w_rsp_ok, w_active, w_expired, w_wdog_clr;
  logic [CNT_WIDTH-1:0] r_cycle_cnt;
  logic [CNT_WIDTH-1:0] r_inst_cnt;

  // Wider index buses: any set bit above the decoded range is undecoded.
  if (INST_NUM_WIDTH > IDX_W) begin : g_idx_wide
    assign w_idx     = inst_num[IDX_W-1:0];
    assign w_idx_oor = |inst_num[INST_NUM_WIDTH-1:IDX_W];
  end else begin : g_idx_narrow
    assign w_idx     = IDX_W'(inst_num);
    assign w_idx_oor = 1'b0;
  end

  assign w_cls_dec = decode_class(w_idx);

  always_comb begin
    w_cls = w_cls_dec;
    if (w_idx_oor) begin
      w_cls         = '0;
      w_cls.is_halt = 1'b1;
      w_cls.no_rd   = 1'b1;
    end
  end

  assign w_st_if    = (r_state == S_IF);
  assign w_st_ifw   = (r_state == S_IFW);
  assign w_st_ex    = (r_state == S_EX);
  assign w_st_mem   = (r_state == S_MEM);
  assign w_st_memw  = (r_state == S_MEMW);
  assign w_st_wb    = (r_state == S_WB);
  assign w_req      = w_st_if | w_st_mem;
  assign w_in_phase = w_req | w_st_ifw | w_st_memw;
  assign w_active   = ~((r_state == S_RST) | halt);
  // IF and MEM are only ever entered from RST, WB or EX.
  assign w_wdog_clr = (r_state == S_RST) | w_st_ex | w_st_wb;

  // A response in the expiring cycle is dropped; the sequencer goes to ERR.
  assign w_rsp_ok = ((w_req & mem_req_ready) | w_st_ifw | w_st_memw)
                    & mem_rsp_valid & ~w_expired;

  exu_seq_wdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_wdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (w_wdog_clr),
    .en     (w_in_phase),
    .expired(w_expired)
  );

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RST:  w_next_state = S_IF;
      S_IF: begin
        if (w_expired)                          w_next_state = S_ERR;
        else if (mem_req_ready & mem_rsp_valid) w_next_state = S_EX;
        else if (mem_req_ready)                 w_next_state = S_IFW;
      end
      S_IFW: begin
        if (w_expired)          w_next_state = S_ERR;
        else if (mem_rsp_valid) w_next_state = S_EX;
      end
      S_EX: begin
        if (w_cls.is_halt)     w_next_state = S_HALT;
        else if (w_cls.is_mem) w_next_state = S_MEM;
        else                   w_next_state = S_WB;
      end
      S_MEM: begin
        if (w_expired)                          w_next_state = S_ERR;
        else if (mem_req_ready & mem_rsp_valid) w_next_state = S_WB;
        else if (mem_req_ready)                 w_next_state = S_MEMW;
      end
      S_MEMW: begin
        if (w_expired)          w_next_state = S_ERR;
        else if (mem_rsp_valid) w_next_state = S_WB;
      end
      S_WB:   w_next_state = S_IF;
      S_HALT: w_next_state = S_HALT;
      S_ERR:  w_next_state = S_ERR;
      default: w_next_state = S_ERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RST;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cycle_cnt <= '0;
      r_inst_cnt  <= '0;
    end else begin
      if (w_active) r_cycle_cnt <= r_cycle_cnt + CNT_WIDTH'(1);
      if (w_st_wb)  r_inst_cnt  <= r_inst_cnt + CNT_WIDTH'(1);
    end
  end

  assign mem_req_valid = w_req;
  assign mem_req_fetch = w_st_if;
  assign mem_req_wen   = w_st_mem & w_cls.is_store;
  assign ir_wen        = (w_st_if | w_st_ifw) & w_rsp_ok;
  assign mem_r_wen     = (w_st_mem | w_st_memw) & w_rsp_ok & ~w_cls.is_store;
  assign pc_wen        = w_st_wb;
  assign rf_wen        = w_st_wb & ~w_cls.no_rd;
  assign halt          = (r_state == S_HALT) | (r_state == S_ERR);
  assign bus_err       = (r_state == S_ERR);
  assign cycle_cnt     = r_cycle_cnt;
  assign inst_cnt      = r_inst_cnt;

endmodule
`default_nettype wire

// File: tb/tb_exu_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_exu_seq_ctrl
// Brief   : Directed self-checking bench for the exu_seq_ctrl sequencer
// Rev     : 1.0  initial release
// ============================================================================
module tb_exu_seq_ctrl;
  import exu_seq_ctrl_pkg::*;

  // Packed control view: {valid, fetch, wen, ir_wen, mem_r_wen, pc_wen, rf_wen, halt, bus_err}
  localparam logic [8:0] M_V  = 9'h100;
  localparam logic [8:0] M_F  = 9'h080;
  localparam logic [8:0] M_W  = 9'h040;
  localparam logic [8:0] M_IR = 9'h020;
  localparam logic [8:0] M_MR = 9'h010;
  localparam logic [8:0] M_PC = 9'h008;
  localparam logic [8:0] M_RF = 9'h004;
  localparam logic [8:0] M_H  = 9'h002;
  localparam logic [8:0] M_E  = 9'h001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  inst_num = 5'd0;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic        mem_req_valid, mem_req_fetch, mem_req_wen, ir_wen, mem_r_wen;
  logic        pc_wen, rf_wen, halt, bus_err;
  logic [63:0] cycle_cnt, inst_cnt;
  logic        valid_s, fetch_s, wen_s, ir_wen_s, mem_r_wen_s, pc_wen_s, rf_wen_s, halt_s, bus_err_s;
  logic [1:0]  cycle_cnt_s, inst_cnt_s;
  logic [8:0]  ctl;
  int          checks = 0;
  int          errors = 0;

  exu_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inst_num(inst_num),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_fetch(mem_req_fetch), .mem_req_wen(mem_req_wen),
    .mem_rsp_valid(mem_rsp_valid), .ir_wen(ir_wen), .mem_r_wen(mem_r_wen),
    .pc_wen(pc_wen), .rf_wen(rf_wen), .halt(halt), .bus_err(bus_err),
    .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt)
  );

  // Narrow-counter copy exposes the modulo wrap of both counters.
  exu_seq_ctrl #(.CNT_WIDTH(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .inst_num(inst_num),
    .mem_req_valid(valid_s), .mem_req_ready(mem_req_ready),
    .mem_req_fetch(fetch_s), .mem_req_wen(wen_s),
    .mem_rsp_valid(mem_rsp_valid), .ir_wen(ir_wen_s), .mem_r_wen(mem_r_wen_s),
    .pc_wen(pc_wen_s), .rf_wen(rf_wen_s), .halt(halt_s), .bus_err(bus_err_s),
    .cycle_cnt(cycle_cnt_s), .inst_cnt(inst_cnt_s)
  );

  assign ctl = {mem_req_valid, mem_req_fetch, mem_req_wen, ir_wen, mem_r_wen,
                pc_wen, rf_wen, halt, bus_err};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

  task automatic cyc(input logic rdy, input logic rsp);
    @(negedge clk);
    mem_req_ready = rdy;
    mem_rsp_valid = rsp;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    inst_num = INST_ADDI;
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (ctl !== 9'h000) begin errors++; $display("FAIL reset_ctl: got %h expected 000", ctl); end
    checks++;
    if (cycle_cnt !== 64'd0 || inst_cnt !== 64'd0) begin
      errors++; $display("FAIL reset_cnt: got cyc=%0d inst=%0d expected 0/0", cycle_cnt, inst_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);
    checks++;
    if (ctl !== (M_V | M_F)) begin errors++; $display("FAIL reset_first_if: got %h expected %h", ctl, M_V | M_F); end
    checks++;
    if (cycle_cnt !== 64'd0) begin errors++; $display("FAIL reset_first_cyc: got %0d expected 0", cycle_cnt); end
  endtask

  task automatic test_zero_wait_addi();
    logic [8:0] exp;
    do_reset();
    inst_num = INST_ADDI;
    for (int i = 0; i < 15; i++) begin
      cyc(1'b1, 1'b1);
      case (i % 3)
        0:       exp = M_V | M_F | M_IR;
        1:       exp = 9'h000;
        default: exp = M_PC | M_RF;
      endcase
      checks++;
      if (ctl !== exp) begin errors++; $display("FAIL addi_ctl[%0d]: got %h expected %h", i, ctl, exp); end
      if (i == 3) begin
        checks++;
        if (inst_cnt !== 64'd1 || cycle_cnt !== 64'd3) begin
          errors++; $display("FAIL addi_first_retire: got inst=%0d cyc=%0d expected 1/3", inst_cnt, cycle_cnt);
        end
      end
    end
    cyc(1'b1, 1'b1);
    checks++;
    if (inst_cnt !== 64'd5 || cycle_cnt !== 64'd15) begin
      errors++; $display("FAIL addi_five: got inst=%0d cyc=%0d expected 5/15", inst_cnt, cycle_cnt);
    end
    checks++;
    if (inst_cnt_s !== 2'd1 || cycle_cnt_s !== 2'd3) begin
      errors++; $display("FAIL cnt_wrap: got inst=%0d cyc=%0d expected 1/3", inst_cnt_s, cycle_cnt_s);
    end
  endtask

  task automatic test_lw_wait();
    bit         rdy_v [9] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    bit         rsp_v [9] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [8:0] exp_v [9] = '{M_V | M_F | M_IR, 9'h000, M_V, M_V, M_V, 9'h000, 9'h000,
                              M_MR, M_PC | M_RF};
    int n_mem_valid = 0;
    int n_mr = 0;
    do_reset();
    inst_num = INST_LW;
    for (int i = 0; i < 9; i++) begin
      cyc(rdy_v[i], rsp_v[i]);
      if (mem_req_valid && !mem_req_fetch) n_mem_valid++;
      if (mem_r_wen) n_mr++;
      checks++;
      if (ctl !== exp_v[i]) begin errors++; $display("FAIL lw_ctl[%0d]: got %h expected %h", i, ctl, exp_v[i]); end
    end
    cyc(1'b0, 1'b0);
    checks++;
    if (n_mem_valid != 3 || n_mr != 1) begin
      errors++; $display("FAIL lw_pulses: got valid=%0d mr=%0d expected 3/1", n_mem_valid, n_mr);
    end
    checks++;
    if (inst_cnt !== 64'd1 || cycle_cnt !== 64'd9) begin
      errors++; $display("FAIL lw_cnt: got inst=%0d cyc=%0d expected 1/9", inst_cnt, cycle_cnt);
    end
  endtask

  task automatic test_sw_beq();
    logic [8:0] exp_v [7] = '{M_V | M_F | M_IR, 9'h000, M_V | M_W, M_PC,
                              M_V | M_F | M_IR, 9'h000, M_PC};
    int n_wen = 0;
    do_reset();
    inst_num = INST_SW;
    for (int i = 0; i < 7; i++) begin
      if (i == 4) inst_num = INST_BEQ;
      cyc(1'b1, 1'b1);
      if (mem_req_wen) n_wen++;
      checks++;
      if (ctl !== exp_v[i]) begin errors++; $display("FAIL sw_beq_ctl[%0d]: got %h expected %h", i, ctl, exp_v[i]); end
    end
    cyc(1'b1, 1'b1);
    checks++;
    if (n_wen != 1) begin errors++; $display("FAIL sw_wen_count: got %0d expected 1", n_wen); end
    checks++;
    if (inst_cnt !== 64'd2 || cycle_cnt !== 64'd7) begin
      errors++; $display("FAIL sw_beq_cnt: got inst=%0d cyc=%0d expected 2/7", inst_cnt, cycle_cnt);
    end
  endtask

  task automatic test_ebreak_halt();
    logic [8:0] exp_v [3] = '{M_V | M_F | M_IR, 9'h000, M_H};
    int bad = 0;
    do_reset();
    inst_num = INST_ADDI;
    for (int i = 0; i < 15; i++) cyc(1'b1, 1'b1);
    inst_num = INST_EBREAK;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1);
      checks++;
      if (ctl !== exp_v[i]) begin errors++; $display("FAIL ebreak_ctl[%0d]: got %h expected %h", i, ctl, exp_v[i]); end
    end
    checks++;
    if (inst_cnt !== 64'd5 || cycle_cnt !== 64'd17) begin
      errors++; $display("FAIL ebreak_cnt: got inst=%0d cyc=%0d expected 5/17", inst_cnt, cycle_cnt);
    end
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, 1'b1);
      if (ctl !== M_H) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL halt_sticky: got %0d bad cycles expected 0", bad); end
    checks++;
    if (cycle_cnt !== 64'd17 || inst_cnt !== 64'd5) begin
      errors++; $display("FAIL halt_frozen: got cyc=%0d inst=%0d expected 17/5", cycle_cnt, inst_cnt);
    end
  endtask

  task automatic test_undecoded();
    logic [8:0] exp_v [3] = '{M_V | M_F | M_IR, 9'h000, M_H};
    do_reset();
    inst_num = 5'd31;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1);
      checks++;
      if (ctl !== exp_v[i]) begin errors++; $display("FAIL undec_ctl[%0d]: got %h expected %h", i, ctl, exp_v[i]); end
    end
    checks++;
    if (inst_cnt !== 64'd0 || cycle_cnt !== 64'd2) begin
      errors++; $display("FAIL undec_cnt: got inst=%0d cyc=%0d expected 0/2", inst_cnt, cycle_cnt);
    end
  endtask

  task automatic test_timeout();
    int bad = 0;
    do_reset();
    inst_num = INST_ADDI;
    for (int i = 1; i <= 254; i++) begin
      cyc(1'b0, 1'b0);
      if (ctl !== (M_V | M_F)) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL timeout_wait: got %0d bad cycles expected 0", bad); end
    cyc(1'b1, 1'b1);
    checks++;
    if ((ctl & (M_V | M_F | M_H | M_E)) !== (M_V | M_F)) begin
      errors++; $display("FAIL timeout_last_if: got %h expected valid+fetch only", ctl);
    end
    cyc(1'b1, 1'b1);
    checks++;
    if (ctl !== (M_H | M_E)) begin errors++; $display("FAIL timeout_err: got %h expected %h", ctl, M_H | M_E); end
    checks++;
    if (cycle_cnt !== 64'd255) begin errors++; $display("FAIL timeout_cyc: got %0d expected 255", cycle_cnt); end
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1);
    checks++;
    if (ctl !== (M_H | M_E) || cycle_cnt !== 64'd255) begin
      errors++; $display("FAIL timeout_sticky: got ctl=%h cyc=%0d expected %h/255", ctl, cycle_cnt, M_H | M_E);
    end
  endtask

  task automatic test_reset_midtx();
    do_reset();
    inst_num = INST_LW;
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b1);
    checks++;
    if (ctl !== M_MR || cycle_cnt !== 64'd3) begin
      errors++; $display("FAIL midtx_pre: got ctl=%h cyc=%0d expected %h/3", ctl, cycle_cnt, M_MR);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (ctl !== 9'h000) begin errors++; $display("FAIL midtx_async_ctl: got %h expected 000", ctl); end
    checks++;
    if (cycle_cnt !== 64'd0 || inst_cnt !== 64'd0) begin
      errors++; $display("FAIL midtx_async_cnt: got cyc=%0d inst=%0d expected 0/0", cycle_cnt, inst_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0, 1'b0);
    checks++;
    if (ctl !== (M_V | M_F) || cycle_cnt !== 64'd0) begin
      errors++; $display("FAIL midtx_restart: got ctl=%h cyc=%0d expected %h/0", ctl, cycle_cnt, M_V | M_F);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait_addi();
    test_lw_wait();
    test_sw_beq();
    test_ebreak_halt();
    test_undecoded();
    test_timeout();
    test_reset_midtx();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
